// File: rtl/semaphore_pkg.sv
// semaphore_pkg: shared FSM states, opcode one-hot encodings and field widths for the semaphore request path
package semaphore_pkg;
    localparam int DATA_W = 4;
    localparam int ADDR_W = 8;
    localparam logic [2:0] OP_CREATE  = 3'b100;
    localparam logic [2:0] OP_RELEASE = 3'b010;
    localparam logic [2:0] OP_ACQUIRE = 3'b001;
    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
endpackage

// File: rtl/semaphore_rr_picker.sv
// semaphore_rr_picker: combinational first-eligible search starting at ptr, wrapping modulo N
module semaphore_rr_picker #(
    parameter int N  = 2,
    parameter int IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          vld
);
    int j;
    always_comb begin
        idx = '0;
        j   = 0;
        // walk offsets downwards so the smallest offset from ptr is the last writer
        for (int k = N - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = j >= N ? j - N : j;
            idx = req[j] ? IW'(j) : idx;
        end
        vld = |req;
    end
endmodule

// File: rtl/semaphore_request_arbiter.sv
// semaphore_request_arbiter: round-robin arbiter forwarding one core's semaphore request to the router port
// optional router timeout with NACK enabled by SEMAPHOREARBITER_TIMEOUT_EN
module semaphore_request_arbiter
    import semaphore_pkg::*;
#(
    parameter int NumberOfCores = 2,
    parameter int TimeoutCycles = 16
) (
    input  logic                          CLK,
    input  logic                          SEMAPHOREARBITER_RESETn,
    input  logic [NumberOfCores-1:0]      SEMAPHOREARBITER_EN_FromCore,
    input  logic [NumberOfCores-1:0]      SEMAPHOREARBITER_CREATE_FromCore,
    input  logic [NumberOfCores-1:0]      SEMAPHOREARBITER_ACQUIRE_FromCore,
    input  logic [NumberOfCores-1:0]      SEMAPHOREARBITER_RELEASE_FromCore,
    input  logic [4*NumberOfCores-1:0]    SEMAPHOREARBITER_Data_FromCore,
    input  logic [8*NumberOfCores-1:0]    SEMAPHOREARBITER_Addr_FromCore,
    output logic [NumberOfCores-1:0]      SEMAPHOREARBITER_ACK_ToCore,
    output logic [NumberOfCores-1:0]      SEMAPHOREARBITER_NACK_ToCore,
    output logic                          SEMAPHOREARBITER_EN_ToRouter,
    output logic                          SEMAPHOREARBITER_CREATE_ToRouter,
    output logic                          SEMAPHOREARBITER_ACQUIRE_ToRouter,
    output logic                          SEMAPHOREARBITER_RELEASE_ToRouter,
    output logic [DATA_W-1:0]             SEMAPHOREARBITER_Data_ToRouter,
    output logic [ADDR_W-1:0]             SEMAPHOREARBITER_Addr_ToRouter,
    input  logic                          SEMAPHOREARBITER_ACK_FromRouter
);
    localparam int IW = NumberOfCores > 1 ? $clog2(NumberOfCores) : 1;

    if (NumberOfCores < 1 || NumberOfCores > 8 || TimeoutCycles < 4) begin : g_bad_param
        $error("semaphore_request_arbiter: NumberOfCores must be 1..8 and TimeoutCycles >= 4");
    end

    state_t                   state, state_nxt;
    logic [NumberOfCores-1:0] elig, ack_q, nack_q;
    logic [IW-1:0]            pick, grant, rr_ptr;
    logic                     pick_vld, ack_fire, timeout;
    logic [2:0]               op, pick_op;
    logic [DATA_W-1:0]        data;
    logic [ADDR_W-1:0]        addr;

    assign elig = SEMAPHOREARBITER_EN_FromCore & (SEMAPHOREARBITER_CREATE_FromCore |
                  SEMAPHOREARBITER_ACQUIRE_FromCore | SEMAPHOREARBITER_RELEASE_FromCore);

    semaphore_rr_picker #(.N(NumberOfCores), .IW(IW)) u_picker (
        .req (elig),
        .ptr (rr_ptr),
        .idx (pick),
        .vld (pick_vld)
    );

    assign pick_op = SEMAPHOREARBITER_CREATE_FromCore[pick]  ? OP_CREATE  :
                     SEMAPHOREARBITER_RELEASE_FromCore[pick] ? OP_RELEASE : OP_ACQUIRE;
    assign ack_fire = state == ISSUE && SEMAPHOREARBITER_ACK_FromRouter;

`ifdef SEMAPHOREARBITER_TIMEOUT_EN
    localparam int CW = $clog2(TimeoutCycles);
    logic [CW-1:0] cnt;
    assign timeout = state == ISSUE && !SEMAPHOREARBITER_ACK_FromRouter && cnt == CW'(TimeoutCycles - 1);
    always_ff @(posedge CLK or negedge SEMAPHOREARBITER_RESETn)
        if (!SEMAPHOREARBITER_RESETn) cnt <= '0;
        else cnt <= state == ISSUE ? cnt + CW'(1) : '0;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state == IDLE  ? (pick_vld ? ISSUE : IDLE) :
                    state == ISSUE ? (ack_fire || timeout ? DONE : ISSUE) : IDLE;
        // the ACK mask is combinational so the router never re-samples a request it just acknowledged
        SEMAPHOREARBITER_EN_ToRouter      = state == ISSUE && !SEMAPHOREARBITER_ACK_FromRouter;
        SEMAPHOREARBITER_CREATE_ToRouter  = state == ISSUE && op[2];
        SEMAPHOREARBITER_RELEASE_ToRouter = state == ISSUE && op[1];
        SEMAPHOREARBITER_ACQUIRE_ToRouter = state == ISSUE && op[0];
    end

    always_ff @(posedge CLK or negedge SEMAPHOREARBITER_RESETn) begin
        if (!SEMAPHOREARBITER_RESETn) begin
            state  <= IDLE;
            rr_ptr <= '0;
            grant  <= '0;
            op     <= '0;
            data   <= '0;
            addr   <= '0;
            ack_q  <= '0;
            nack_q <= '0;
        end else begin
            state  <= state_nxt;
            ack_q  <= ack_fire ? NumberOfCores'(1) << grant : '0;
            nack_q <= timeout  ? NumberOfCores'(1) << grant : '0;
            if (state == IDLE && pick_vld) begin
                grant <= pick;
                op    <= pick_op;
                data  <= SEMAPHOREARBITER_Data_FromCore[DATA_W*pick +: DATA_W];
                addr  <= SEMAPHOREARBITER_Addr_FromCore[ADDR_W*pick +: ADDR_W];
            end
            if (state == DONE) rr_ptr <= grant == IW'(NumberOfCores - 1) ? '0 : grant + IW'(1);
        end
    end

    assign SEMAPHOREARBITER_ACK_ToCore    = ack_q;
    assign SEMAPHOREARBITER_NACK_ToCore   = nack_q;
    assign SEMAPHOREARBITER_Data_ToRouter = data;
    assign SEMAPHOREARBITER_Addr_ToRouter = addr;
endmodule
